// File: rtl/jmp_issue_arb_pkg.sv
// Shared definitions for the jump-unit issue arbiter: widths, function codes
// understood by the jump unit, and the controller state encoding.
package jmp_issue_arb_pkg;

  localparam int FCT_W   = 6;
  localparam int DATA_W  = 32;
  localparam int LAT_DEF = 2;
  localparam int CNT_W   = 4;

  localparam logic [FCT_W-1:0] FCT_NOP           = 6'h00;
  localparam logic [FCT_W-1:0] FCT_JMP           = 6'h20;
  localparam logic [FCT_W-1:0] FCT_JSR           = 6'h21;
  localparam logic [FCT_W-1:0] FCT_RET           = 6'h22;
  localparam logic [FCT_W-1:0] FCT_JSR_COROUTINE = 6'h23;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // True for codes the jump unit turns into a real target.
  function automatic logic is_jump(input logic [FCT_W-1:0] fct);
    return fct inside {FCT_JMP, FCT_JSR, FCT_RET, FCT_JSR_COROUTINE};
  endfunction

endpackage

// File: rtl/jmp_issue_arb_rr_arb2.sv
// Two-requester round-robin arbiter. Bit 0 is slot A, bit 1 is slot B.
// On a tie the slot that was not granted last wins; after reset A wins first.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last;  // 1 = B was granted most recently

  // One-hot grant, only while enabled.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  // Remember who won; reset pretends B went last so A is favoured.
  always_ff @(posedge clk) begin
    if (!rst_n)      last <= 1'b1;
    else if (|gnt)   last <= gnt[1];
  end

endmodule

// File: rtl/jmp_issue_arb.sv
// Issue controller for the shared jump-target unit.
//
//   state | meaning
//   IDLE  | unit free, grants allowed when not flushing
//   EXEC  | op issued to unit, latency counter running
//   DONE  | result registered, res_valid strobe (unless flushed)
//
// The counter is loaded with LAT-1 on the grant edge and the result is
// sampled on the edge where it is already 0, so the sample edge lands LAT
// edges after the grant edge.
module jmp_issue_arb #(
  parameter int FCT_W  = jmp_issue_arb_pkg::FCT_W,
  parameter int DATA_W = jmp_issue_arb_pkg::DATA_W,
  parameter int LAT    = jmp_issue_arb_pkg::LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic [FCT_W-1:0]  a_fct,
  input  logic [DATA_W-1:0] a_op2,
  output logic              a_gnt,
  input  logic              b_req,
  input  logic [FCT_W-1:0]  b_fct,
  input  logic [DATA_W-1:0] b_op2,
  output logic              b_gnt,
  input  logic              flush,
  output logic [FCT_W-1:0]  ju_fct,
  output logic [DATA_W-1:0] ju_op2,
  input  logic [DATA_W-1:0] ju_data,
  output logic              res_valid,
  output logic              res_id,
  output logic [DATA_W-1:0] res_target,
  output logic              busy
);
  import jmp_issue_arb_pkg::*;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             owner;
  logic             arb_en;
  logic [1:0]       gnt;

  assign arb_en = (state == ST_IDLE) && !flush;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (arb_en),
    .req   ({b_req, a_req}),
    .gnt   (gnt)
  );

  assign a_gnt     = gnt[0];
  assign b_gnt     = gnt[1];
  assign busy      = (state != ST_IDLE);
  assign res_valid = (state == ST_DONE) && !flush;

  // Next-state decode; flush returns to IDLE from any busy state.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (|gnt) state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (flush)           state_nxt = ST_IDLE;
        else if (cnt == '0)  state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register, operand latch, latency counter and result capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      owner      <= 1'b0;
      ju_fct     <= '0;
      ju_op2     <= '0;
      res_id     <= 1'b0;
      res_target <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (|gnt) begin
            ju_fct <= gnt[1] ? b_fct : a_fct;
            ju_op2 <= gnt[1] ? b_op2 : a_op2;
            owner  <= gnt[1];
            cnt    <= CNT_W'(LAT - 1);
          end
        end
        ST_EXEC: begin
          if (flush) begin
            ju_fct <= '0;
          end else if (cnt == '0) begin
            res_target <= ju_data;
            res_id     <= owner;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: ju_fct <= '0;
        default: ju_fct <= '0;
      endcase
    end
  end

endmodule
